shared_dmem_arbiter: RTL

- Shares the single data-memory port among the MEM stages of NUM_CORES processor cores.
- Each core's MEM stage presents one load, store or SAD buffer-fill access per cycle.
- The arbiter grants one core per cycle using round-robin priority, with an optional bounded lock so a core can stream consecutive SAD loads.
- Losing cores get a combinational stall that feeds their pipeline hazard/stall logic. Read data returns one cycle after the grant.

---
 rtl/shared_dmem_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/shared_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port among NUM_CORES MEM stages,
// with a bounded lock so one core can stream consecutive SAD loads.
module shared_dmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES-1:0]             core_we,
  input  logic [NUM_CORES-1:0]             core_lock,
  input  logic [2*NUM_CORES-1:0]           core_size,
  input  logic [ADDR_WIDTH*NUM_CORES-1:0]  core_addr,
  input  logic [DATA_WIDTH*NUM_CORES-1:0]  core_wdata,
  output logic [NUM_CORES-1:0]             core_stall,
  output logic [NUM_CORES-1:0]             core_rvalid,
  output logic [DATA_WIDTH-1:0]            core_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [1:0]                       mem_size,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam int BST_W = $clog2(MAX_BURST + 1);
  localparam logic [BST_W-1:0] BURST_MAX = BST_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_CORES - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_owner;
  logic [BST_W-1:0]       r_burst_cnt;
  logic [NUM_CORES-1:0]   r_rd_pending;

  logic                   w_hold;
  logic [PTR_W-1:0]       w_scan_base;
  logic [PTR_W-1:0]       w_scan_ptr;
  logic [PTR_W-1:0]       w_gidx;
  logic                   w_gnt_any;
  logic [NUM_CORES-1:0]   w_grant;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + PTR_W'(1);
  endfunction

  // Owner keeps the port while it requests and still has burst budget left.
  assign w_hold      = (r_state == LOCKED) && core_req[r_owner] && (r_burst_cnt < BURST_MAX);
  assign w_scan_base = (r_state == LOCKED && r_burst_cnt == BURST_MAX) ? wrap_inc(r_owner)
                                                                      : r_rr_ptr;

  always_comb begin
    w_gidx     = '0;
    w_gnt_any  = 1'b0;
    w_scan_ptr = w_scan_base;
    if (w_hold) begin
      w_gidx    = r_owner;
      w_gnt_any = 1'b1;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!w_gnt_any && core_req[w_scan_ptr]) begin
          w_gidx    = w_scan_ptr;
          w_gnt_any = 1'b1;
        end
        w_scan_ptr = wrap_inc(w_scan_ptr);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_gnt_any) w_grant[w_gidx] = 1'b1;
  end

  assign mem_en      = w_gnt_any;
  assign mem_we      = w_gnt_any & core_we[w_gidx];
  assign mem_size    = w_gnt_any ? core_size[w_gidx*2 +: 2] : 2'b00;
  assign mem_addr    = w_gnt_any ? core_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_wdata   = w_gnt_any ? core_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign core_stall  = core_req & ~w_grant;
  assign core_rvalid = r_rd_pending;
  assign core_rdata  = mem_rdata;

  // Grant cycle -> read-return cycle boundary; lock/round-robin bookkeeping
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_burst_cnt  <= '0;
      r_rd_pending <= '0;
    end else begin
      r_rd_pending <= w_grant & ~core_we;
      if (!w_gnt_any) begin
        r_state <= IDLE;
      end else if (w_hold && core_lock[w_gidx]) begin
        r_burst_cnt <= r_burst_cnt + BST_W'(1);
      end else if (core_lock[w_gidx]) begin
        r_state     <= LOCKED;
        r_owner     <= w_gidx;
        r_burst_cnt <= BST_W'(1);
      end else begin
        r_state  <= IDLE;
        r_rr_ptr <= wrap_inc(w_gidx);
      end
    end
  end

endmodule
